// File: rtl/wash_cycle_if.sv
// Bundles the washing-machine controller's front-end inputs and its display/actuator outputs.
// The master side is the button/switch front end, and the slave side is the controller.
interface wash_cycle_if;
  logic       tick_1s;
  logic       start;
  logic       pause;
  logic       abort;
  logic [2:0] mode;
  logic [2:0] phase;
  logic       paused;
  logic       busy;
  logic [9:0] remaining;
  logic       done;
  logic       valve_on;
  logic       motor_on;
  logic       drain_on;

  // All inputs are single-cycle pulses except mode, which is level and sampled only on a launching start.
  modport master (
    output tick_1s, start, pause, abort, mode,
    input  phase, paused, busy, remaining, done, valve_on, motor_on, drain_on
  );

  modport slave (
    input  tick_1s, start, pause, abort, mode,
    output phase, paused, busy, remaining, done, valve_on, motor_on, drain_on
  );
endinterface

// File: rtl/wash_cycle_ctrl.sv
// Washing-machine program sequencer: FILL -> WASH -> RINSE -> SPIN -> DONE, driven by a 1 Hz tick.
// Provides pause/resume and abort; all outputs are registered, and the phase output is the FSM state.
module wash_cycle_ctrl #(
  parameter int T_FILL   = 5,
  parameter int T_WASH_S = 10,
  parameter int T_WASH_M = 20,
  parameter int T_WASH_B = 30,
  parameter int T_RINSE  = 10,
  parameter int T_SPIN   = 8,
  parameter int T_DRY    = 15
) (
  input  logic         clk,
  input  logic         rst,
  wash_cycle_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WASH  = 3'd2,
    S_RINSE = 3'd3,
    S_SPIN  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [9:0] L_FILL   = 10'(T_FILL);
  localparam logic [9:0] L_WASH_S = 10'(T_WASH_S);
  localparam logic [9:0] L_WASH_M = 10'(T_WASH_M);
  localparam logic [9:0] L_WASH_B = 10'(T_WASH_B);
  localparam logic [9:0] L_RINSE  = 10'(T_RINSE);
  localparam logic [9:0] L_SPIN   = 10'(T_SPIN);
  localparam logic [9:0] L_DRY    = 10'(T_DRY);

  state_t     r_state, w_state;
  logic [9:0] r_cnt, w_cnt;
  logic [9:0] r_rem, w_rem;
  logic       r_paused, w_paused;
  logic [1:0] r_mode, w_mode;
  logic       r_done, r_busy, r_valve, r_motor, r_drain;
  logic       w_running;

  function automatic logic [9:0] wash_time(input logic [1:0] m);
    case (m)
      2'd1:    wash_time = L_WASH_S;
      2'd2:    wash_time = L_WASH_M;
      default: wash_time = L_WASH_B;
    endcase
  endfunction

  assign w_running = (r_state == S_FILL) || (r_state == S_WASH) ||
                     (r_state == S_RINSE) || (r_state == S_SPIN);

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_rem    = r_rem;
    w_paused = r_paused;
    w_mode   = r_mode;
    if (w_running) begin
      // Priority inside a running program: abort, then pause toggle, then tick.
      if (bus.abort) begin
        w_state  = S_IDLE;
        w_cnt    = '0;
        w_rem    = '0;
        w_paused = 1'b0;
        w_mode   = '0;
      end else if (bus.pause) begin
        w_paused = !r_paused;
      end else if (bus.tick_1s && !r_paused) begin
        w_cnt = r_cnt - 10'd1;
        w_rem = r_rem - 10'd1;
        if (r_cnt == 10'd1) begin
          case (r_state)
            S_FILL:  begin w_state = S_WASH;  w_cnt = wash_time(r_mode); end
            S_WASH:  begin w_state = S_RINSE; w_cnt = L_RINSE;           end
            S_RINSE: begin w_state = S_SPIN;  w_cnt = L_SPIN;            end
            default: begin w_state = S_DONE;  w_cnt = '0;                end
          endcase
        end
      end
    end else if (r_state == S_DONE) begin
      if (bus.abort || bus.start) begin
        w_state = S_IDLE;
        w_mode  = '0;
      end
    end else if (r_state == S_IDLE) begin
      if (bus.start && !bus.mode[2]) begin
        w_mode = bus.mode[1:0];
        if (bus.mode[1:0] == 2'd0) begin
          w_state = S_SPIN;
          w_cnt   = L_DRY;
          w_rem   = L_DRY;
        end else begin
          w_state = S_FILL;
          w_cnt   = L_FILL;
          w_rem   = L_FILL + wash_time(bus.mode[1:0]) + L_RINSE + L_SPIN;
        end
      end
    end else begin
      w_state  = S_IDLE;
      w_cnt    = '0;
      w_rem    = '0;
      w_paused = 1'b0;
      w_mode   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_paused <= 1'b0;
      r_mode   <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_valve  <= 1'b0;
      r_motor  <= 1'b0;
      r_drain  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_rem    <= w_rem;
      r_paused <= w_paused;
      r_mode   <= w_mode;
      // Flags derive from the next state so they change on the same edge as phase.
      r_done   <= (w_state == S_DONE) && (r_state != S_DONE);
      r_busy   <= (w_state == S_FILL) || (w_state == S_WASH) ||
                  (w_state == S_RINSE) || (w_state == S_SPIN);
      r_valve  <= (w_state == S_FILL) && !w_paused;
      r_motor  <= ((w_state == S_WASH) || (w_state == S_RINSE) ||
                   (w_state == S_SPIN)) && !w_paused;
      r_drain  <= (w_state == S_SPIN) && !w_paused;
    end
  end

  assign bus.phase     = r_state;
  assign bus.paused    = r_paused;
  assign bus.busy      = r_busy;
  assign bus.remaining = r_rem;
  assign bus.done      = r_done;
  assign bus.valve_on  = r_valve;
  assign bus.motor_on  = r_motor;
  assign bus.drain_on  = r_drain;

endmodule
